julia_pixel_engine: RTL

- Upstream producer for the frame buffer: computes one 800x480 Julia-set frame, one pixel at a time, in fixed point.
- Each pixel is presented as a 32-bit RGB word plus a 22-bit linear SDRAM word address on a valid/ready handshake.
- Consumer is the memory control logic, which writes each word through the SDRAM controller and later reads it back to the LCD FIFO.
- Replaces the address-pattern fill used during bring-up.

---
 rtl/julia_pixel_engine.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/julia_pixel_engine.sv
// julia_pixel_engine: renders one Julia-set frame in Q4.12 fixed point, one pixel per valid/ready transfer; define JULIA_PALETTE_EN for the colour palette instead of greyscale.
module julia_pixel_engine #(
    parameter int X_PX      = 800,
    parameter int Y_PX      = 480,
    parameter int MAX_ITER  = 255,
    parameter int FRAC_BITS = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] c_re,
    input  logic [15:0] c_im,
    input  logic [15:0] x_start,
    input  logic [15:0] y_start,
    input  logic [15:0] step,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic [21:0] pixel_address,
    output logic [31:0] pixel_data,
    output logic        busy,
    output logic        frame_done
);
    localparam int XW = X_PX > 1 ? $clog2(X_PX) : 1;
    typedef enum logic [1:0] {IDLE, INIT, ITER, EMIT} state_t;
    state_t             state_q, state_d;
    logic signed [15:0] c_re_q, c_re_d, c_im_q, c_im_d, x0_q, x0_d;
    logic signed [15:0] cur_re_q, cur_re_d, cur_im_q, cur_im_d, z_re_q, z_re_d, z_im_q, z_im_d;
    logic [15:0]        step_q, step_d;
    logic [7:0]         n_q, n_d;
    logic [XW-1:0]      x_q, x_d;
    logic [21:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d, colour;
    logic               done_q, done_d;
    logic signed [31:0] p_rr, p_ii, p_ri, re2, im2, nre, nim;
    logic [19:0]        mag;
    logic               escape, max_hit, last, wrap;
    function automatic logic signed [15:0] sat(input logic signed [31:0] v);
        return v > 32'sd32767 ? 16'sh7fff : v < -32'sd32768 ? 16'sh8000 : v[15:0];
    endfunction
    assign p_rr    = 32'(z_re_q) * 32'(z_re_q);
    assign p_ii    = 32'(z_im_q) * 32'(z_im_q);
    assign p_ri    = 32'(z_re_q) * 32'(z_im_q);
    assign re2     = p_rr >>> FRAC_BITS;
    assign im2     = p_ii >>> FRAC_BITS;
    assign mag     = re2[19:0] + im2[19:0];
    assign escape  = mag > 20'd16384;
    // doubling folded into a one-bit-shorter shift so 2*re*im never overflows
    assign nre     = re2 - im2 + 32'(c_re_q);
    assign nim     = (p_ri >>> (FRAC_BITS - 1)) + 32'(c_im_q);
    assign max_hit = n_q == 8'(MAX_ITER);
    assign last    = addr_q == 22'(X_PX * Y_PX - 1);
    assign wrap    = x_q == XW'(X_PX - 1);
`ifdef JULIA_PALETTE_EN
    assign colour  = {8'd0, n_q, n_q[6:0], 1'b0, n_q[5:0], 2'b0};
`else
    assign colour  = {8'd0, n_q, n_q, n_q};
`endif
    assign pixel_valid   = state_q == EMIT;
    assign busy          = state_q != IDLE;
    assign pixel_address = addr_q;
    assign pixel_data    = data_q;
    assign frame_done    = done_q;
    // state and datapath registers; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            c_re_q   <= '0;
            c_im_q   <= '0;
            x0_q     <= '0;
            step_q   <= '0;
            cur_re_q <= '0;
            cur_im_q <= '0;
            z_re_q   <= '0;
            z_im_q   <= '0;
            n_q      <= '0;
            x_q      <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            c_re_q   <= c_re_d;
            c_im_q   <= c_im_d;
            x0_q     <= x0_d;
            step_q   <= step_d;
            cur_re_q <= cur_re_d;
            cur_im_q <= cur_im_d;
            z_re_q   <= z_re_d;
            z_im_q   <= z_im_d;
            n_q      <= n_d;
            x_q      <= x_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end
    // frame sequencing: latch on start, iterate each pixel, hold the result until accepted, walk to the next pixel
    always_comb begin
        state_d  = state_q;
        c_re_d   = c_re_q;
        c_im_d   = c_im_q;
        x0_d     = x0_q;
        step_d   = step_q;
        cur_re_d = cur_re_q;
        cur_im_d = cur_im_q;
        z_re_d   = z_re_q;
        z_im_d   = z_im_q;
        n_d      = n_q;
        x_d      = x_q;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                c_re_d   = c_re;
                c_im_d   = c_im;
                x0_d     = x_start;
                step_d   = step;
                cur_re_d = x_start;
                cur_im_d = y_start;
                x_d      = '0;
                addr_d   = '0;
                state_d  = INIT;
            end
            INIT: begin
                z_re_d  = cur_re_q;
                z_im_d  = cur_im_q;
                n_d     = '0;
                state_d = ITER;
            end
            ITER: if (escape || max_hit) begin
                data_d  = max_hit ? 32'd0 : colour;
                state_d = EMIT;
            end else begin
                z_re_d = sat(nre);
                z_im_d = sat(nim);
                n_d    = n_q + 8'd1;
            end
            EMIT: if (pixel_ready) begin
                if (last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    addr_d   = addr_q + 22'd1;
                    x_d      = wrap ? '0 : x_q + XW'(1);
                    cur_re_d = wrap ? x0_q : cur_re_q + step_q;
                    cur_im_d = wrap ? cur_im_q - step_q : cur_im_q;
                    state_d  = INIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
